serial_adder_n: RTL
===================

# serial_adder_n

Parametrised bit-serial adder/subtractor that processes one bit per clock through a single registered full-adder cell. It replaces the combinational one-bit full adder in multi-bit lab datapaths where area matters more than latency. It adds start/busy/done handshaking, subtract mode, and carry-out and signed-overflow flags.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset; has priority over all other inputs.
- start  in  1  request a new operation; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while state = RUN.
- done  out  1  one-cycle completion pulse, registered.
- sum  out  WIDTH  result, registered; holds until the next completed operation.
- cout  out  1  final carry out; in subtract mode 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a into shift register ra.
  - Latches b into rb, or ~b when sub=1.
  - Sets carry register c = sub, clears bit counter n and result shift register rs, and goes to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - s = ra[0]^rb[0]^c; c <= majority(ra[0], rb[0], c).
  - rs <= {s, rs[WIDTH-1:1]}; ra and rb shift right by one.
  - n <= n+1.
  - On the edge that processes bit WIDTH-1 (n = WIDTH-1):
    - sum <= {s, rs[WIDTH-1:1]}.
    - cout <= new carry.
    - ovf <= old c XOR new carry (old c is the carry into the MSB).
    - done <= 1; go to DONE.
- DONE: done=1 for exactly this cycle; the next edge clears done and goes to IDLE unconditionally.
- start in RUN or DONE is ignored, not queued. a, b and sub changes after acceptance have no effect.
- Counter width: $clog2(WIDTH); wraps to 0 on entry to RUN.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, internal registers 0.
- Start accepted at edge t0:
  - busy=1 from t0 through t0+WIDTH-1.
  - done=1 and sum/cout/ovf valid from edge t0+WIDTH.
  - done=0 at edge t0+WIDTH+1.
- Latency: WIDTH cycles from accepting edge to done.
- Throughput: one operation per WIDTH+2 cycles with start held high; the next start is accepted at edge t0+WIDTH+2.
- Reset mid-RUN aborts the operation:
  - No done pulse.
  - sum, cout and ovf go to 0 at the reset edge.
- Reset coincident with start: reset wins; the operation is not accepted.
- sum, cout and ovf change only at the DONE-entry edge or on reset; they never glitch during RUN.

## Test plan
- WIDTH=8, a=0x3C, b=0x45, sub=0 -> sum=0x81, cout=0, ovf=1; done exactly 8 cycles after the accepting edge; busy high for 8 cycles.
- WIDTH=8:
  - 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
  - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, subtract mode:
  - 0x05-0x07 -> sum=0xFE, cout=0, ovf=0.
  - 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- start held high with a and b changed every cycle -> results match operands captured at each accepting edge; operations start every 10 cycles; pulses during RUN and DONE are ignored.
- Reset asserted on the 4th RUN cycle -> busy=0 and sum/cout/ovf=0 on the next cycle, no done pulse; a following 0x12+0x34 gives 0x46.
- WIDTH=2, exhaustive over a, b and sub (32 cases) -> sum, cout and ovf match the behavioural model (a ± b) for every case; the bench prints one line per case with inputs, flags and sum.

Source files
------------

// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_n
// Description : Bit-serial adder/subtractor, one bit per clock through a single
//               registered full-adder cell, with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-2:0] rs_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    n_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] rs_d;

    // Full-adder cell on the current LSBs; rs_d is the result with this bit on top.
    assign s_d  = ra_q[0] ^ rb_q[0] ^ c_q;
    assign c_d  = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    assign rs_d = {s_d, rs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            sum_q   <= '0;
            n_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
                        ra_q    <= a_i;
                        rb_q    <= sub_i ? ~b_i : b_i;
                        c_q     <= sub_i;
                        n_q     <= '0;
                        rs_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rs_q <= rs_d[WIDTH-1:1];
                    ra_q <= ra_q >> 1;
                    rb_q <= rb_q >> 1;
                    c_q  <= c_d;
                    n_q  <= n_q + CW'(1);
                    if (n_q == LAST_BIT) begin
                        sum_q   <= rs_d;
                        cout_q  <= c_d;
                        ovf_q   <= c_q ^ c_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire
